// File: rtl/mipi_csi2_depacketizer.sv
// CSI-2 byte-stream depacketizer: header parse, VC filter, RAW8/10/12 unpack to one pixel per clock.
// Optional payload CRC-16 check is built when MIPI_CSI2_CRC_EN is defined.
module mipi_csi2_depacketizer #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  phy_we,
  input  logic [7:0]            phy_data,
  input  logic [1:0]            vc_sel,
  input  logic                  vc_any,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic [1:0]            vco,
  output logic [5:0]            dt_o,
  output logic                  pkt_err,
  output logic                  crc_err
);

  localparam int unsigned PIX_W = 12;
  localparam int unsigned NBUF  = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_EOT     = 3'd5;
`ifdef MIPI_CSI2_CRC_EN
  localparam logic [2:0] S_POST    = S_CRC;
`else
  localparam logic [2:0] S_POST    = S_DRAIN;
`endif

  logic [2:0]                  r_state, w_state_nxt;
  logic [1:0]                  r_vc;
  logic [5:0]                  r_dt;
  logic [1:0]                  r_bytecnt;
  logic [15:0]                 r_wc_hdr;
  logic [15:0]                 r_wc;
  logic [2:0]                  r_gcnt;
  logic [3:0][7:0]             r_gb;
  logic [NBUF-1:0][PIX_W-1:0]  r_buf;
  logic [2:0]                  r_bcnt;
  logic [1:0]                  r_rd;
`ifdef MIPI_CSI2_CRC_EN
  logic [15:0]                 r_crc;
  logic [7:0]                  r_crc_lsb;
`endif

  logic                        w_vc_ok, w_raw, w_fs, w_fe, w_start, w_pkt_err, w_crc_bad;
  logic                        w_byte, w_grp_done, w_emit;
  logic [2:0]                  w_gsize, w_npix, w_bcnt_nxt;
  logic [NBUF-1:0][PIX_W-1:0]  w_pix;

`ifdef MIPI_CSI2_CRC_EN
  // Reflected CRC-16/0x1021 (0x8408), one byte LSB first
  function automatic logic [15:0] f_crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 8; i++) v = (v[0] ^ b[i]) ? ((v >> 1) ^ 16'h8408) : (v >> 1);
    return v;
  endfunction
`endif

  assign w_vc_ok    = vc_any || (r_vc == vc_sel);
  assign w_raw      = (r_dt == 6'h2A) || (r_dt == 6'h2B) || (r_dt == 6'h2C);
  assign w_byte     = (r_state == S_PAYLOAD) && phy_we;
  assign w_grp_done = w_byte && (r_gcnt == (w_gsize - 3'd1));
  assign w_emit     = (r_bcnt != 3'd0);
  assign w_bcnt_nxt = w_grp_done ? w_npix : (w_emit ? (r_bcnt - 3'd1) : r_bcnt);

  // Group geometry and pixel assembly; the current byte always closes the group
  always_comb begin
    w_pix   = '0;
    w_gsize = 3'd1;
    w_npix  = 3'd1;
    case (dt_o)
      6'h2B: begin
        w_gsize = 3'd5;
        w_npix  = 3'd4;
        for (int k = 0; k < 4; k++) w_pix[k] = PIX_W'({r_gb[k], phy_data[2*k +: 2]});
      end
      6'h2C: begin
        w_gsize  = 3'd3;
        w_npix   = 3'd2;
        w_pix[0] = {r_gb[0], phy_data[3:0]};
        w_pix[1] = {r_gb[1], phy_data[7:4]};
      end
      default: w_pix[0] = PIX_W'(phy_data);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fs        = 1'b0;
    w_fe        = 1'b0;
    w_start     = 1'b0;
    w_pkt_err   = 1'b0;
    w_crc_bad   = 1'b0;
    case (r_state)
      S_IDLE:    if (phy_we) w_state_nxt = S_HEADER;
      S_HEADER: begin
        if (phy_we && (r_bytecnt == 2'd2)) begin
          w_state_nxt = S_EOT;
          if (w_vc_ok) begin
            if (r_dt == 6'h00)      w_fs = 1'b1;
            else if (r_dt == 6'h01) w_fe = 1'b1;
            else if (w_raw) begin
              w_start     = 1'b1;
              w_state_nxt = (r_wc_hdr == 16'd0) ? S_POST : S_PAYLOAD;
            end
            else if (r_dt >= 6'h20) w_pkt_err = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (!phy_we) begin
          w_pkt_err   = 1'b1;
          w_state_nxt = S_DRAIN;
        end
        else if (r_wc == 16'd1) w_state_nxt = S_POST;
      end
`ifdef MIPI_CSI2_CRC_EN
      S_CRC: begin
        if (phy_we && (r_bytecnt == 2'd1)) begin
          w_state_nxt = S_DRAIN;
          w_crc_bad   = ({phy_data, r_crc_lsb} != r_crc);
        end
      end
`endif
      S_DRAIN:   if (r_bcnt == 3'd0) w_state_nxt = S_EOT;
      S_EOT:     if (!phy_we) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_fs        = 1'b0;
      w_fe        = 1'b0;
      w_start     = 1'b0;
      w_pkt_err   = 1'b0;
      w_crc_bad   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dato      <= '0;
      dvo       <= 1'b0;
      lvo       <= 1'b0;
      fvo       <= 1'b0;
      vco       <= 2'd0;
      dt_o      <= 6'd0;
      pkt_err   <= 1'b0;
      crc_err   <= 1'b0;
      r_vc      <= 2'd0;
      r_dt      <= 6'd0;
      r_bytecnt <= 2'd0;
      r_wc_hdr  <= 16'd0;
      r_wc      <= 16'd0;
      r_gcnt    <= 3'd0;
      r_gb      <= '0;
      r_buf     <= '0;
      r_bcnt    <= 3'd0;
      r_rd      <= 2'd0;
`ifdef MIPI_CSI2_CRC_EN
      r_crc     <= 16'hFFFF;
      r_crc_lsb <= 8'd0;
`endif
    end
    else begin
      pkt_err <= w_pkt_err;
      crc_err <= w_crc_bad;
      if ((r_state == S_IDLE) && phy_we) begin
        {r_vc, r_dt} <= phy_data;
        r_bytecnt    <= 2'd0;
      end
      if ((r_state == S_HEADER) && phy_we) begin
        r_bytecnt <= r_bytecnt + 2'd1;
        if (r_bytecnt == 2'd0) r_wc_hdr[7:0]  <= phy_data;
        if (r_bytecnt == 2'd1) r_wc_hdr[15:8] <= phy_data;
      end
      if (w_fs) begin
        fvo <= 1'b1;
        vco <= r_vc;
      end
      if (w_fe) fvo <= 1'b0;
      if (w_start) begin
        r_wc      <= r_wc_hdr;
        dt_o      <= r_dt;
        r_gcnt    <= 3'd0;
        r_bytecnt <= 2'd0;
`ifdef MIPI_CSI2_CRC_EN
        r_crc     <= 16'hFFFF;
`endif
      end
      if (w_byte) begin
        r_wc <= r_wc - 16'd1;
`ifdef MIPI_CSI2_CRC_EN
        r_crc <= f_crc_byte(r_crc, phy_data);
`endif
        if (w_grp_done) r_gcnt <= 3'd0;
        else begin
          r_gb[r_gcnt[1:0]] <= phy_data;
          r_gcnt            <= r_gcnt + 3'd1;
        end
      end
      if ((r_state == S_PAYLOAD) && !phy_we) r_gcnt <= 3'd0;
`ifdef MIPI_CSI2_CRC_EN
      if ((r_state == S_CRC) && phy_we) begin
        r_bytecnt <= r_bytecnt + 2'd1;
        if (r_bytecnt == 2'd0) r_crc_lsb <= phy_data;
      end
`endif
      // Head of buffer is read before a same-cycle reload overwrites it
      dvo <= w_emit;
      if (w_emit) begin
        dato <= DATA_WIDTH'(r_buf[r_rd]);
        r_rd <= r_rd + 2'd1;
      end
      if (w_grp_done) begin
        r_buf <= w_pix;
        r_rd  <= 2'd0;
      end
      r_bcnt <= w_bcnt_nxt;
      lvo    <= w_emit || (lvo && ((w_bcnt_nxt != 3'd0) || (w_state_nxt == S_PAYLOAD)));
      if (!enable) begin
        dvo    <= 1'b0;
        lvo    <= 1'b0;
        fvo    <= 1'b0;
        r_bcnt <= 3'd0;
        r_gcnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi2_depacketizer.sv
// Bench for mipi_csi2_depacketizer: directed test-plan packets plus random packets vs a packet-level model.
// Expects crc_err activity only when MIPI_CSI2_CRC_EN is defined.
module tb_mipi_csi2_depacketizer;
  localparam int unsigned DW = 12;
`ifdef MIPI_CSI2_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb, enable, phy_we, vc_any;
  logic [7:0]    phy_data;
  logic [1:0]    vc_sel;
  logic [DW-1:0] dato;
  logic          dvo, lvo, fvo, pkt_err, crc_err;
  logic [1:0]    vco;
  logic [5:0]    dt_o;

  always #5 clk = ~clk;

  mipi_csi2_depacketizer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .phy_we(phy_we), .phy_data(phy_data),
    .vc_sel(vc_sel), .vc_any(vc_any), .dato(dato), .dvo(dvo), .lvo(lvo), .fvo(fvo),
    .vco(vco), .dt_o(dt_o), .pkt_err(pkt_err), .crc_err(crc_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Output monitor, sampled mid-cycle
  logic [DW-1:0] mon_pix [0:8191];
  int mon_n = 0, mon_lvo = 0, mon_pe = 0, mon_ce = 0, mon_bad = 0;
  always @(negedge clk) begin
    if (dvo && mon_n < 8192) begin
      mon_pix[mon_n] = dato;
      mon_n++;
    end
    if (lvo) mon_lvo++;
    if (pkt_err) mon_pe++;
    if (crc_err) mon_ce++;
    if (dvo && !lvo) mon_bad++;
  end

  logic       fvo_m = 1'b0;
  logic [1:0] vco_m = 2'd0;
  logic [5:0] dt_m  = 6'd0;
  logic       fvo_at_end;
  logic [7:0] tx_q[$];
  logic [7:0] pay_q[$];
  int         exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clk); #1;
    phy_we   = 1'b1;
    phy_data = b;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    phy_we     = 1'b0;
    phy_data   = 8'd0;
    fvo_at_end = fvo;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc16(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return c;
  endfunction

  task automatic fill_pay(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  // Sends one packet and checks everything it should have produced
  task automatic run_pkt(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input int n_send, input bit corrupt);
    int p0, l0, e0, c0, b0, gsize, npix, groups, span, got, base, exp_pe, exp_ce;
    bit acc, raw;
    logic [15:0] crc;
    tx_q.delete();
    tx_q.push_back({vc, dt});
    tx_q.push_back(wc[7:0]);
    tx_q.push_back(wc[15:8]);
    tx_q.push_back(8'($urandom));
    if (dt >= 6'h10) begin
      for (int i = 0; i < n_send; i++) tx_q.push_back(pay_q[i]);
      if (n_send == int'(wc)) begin
        crc = crc16(n_send);
        if (corrupt) crc = crc ^ 16'h0040;
        tx_q.push_back(crc[7:0]);
        tx_q.push_back(crc[15:8]);
      end
    end
    p0 = mon_n; l0 = mon_lvo; e0 = mon_pe; c0 = mon_ce; b0 = mon_bad;
    foreach (tx_q[i]) drive_byte(tx_q[i]);
    idle(14);

    acc = vc_any || (vc == vc_sel);
    raw = (dt == 6'h2A) || (dt == 6'h2B) || (dt == 6'h2C);
    exp_q.delete();
    gsize = 1; npix = 0; groups = 0;
    if (acc && dt == 6'h00) begin fvo_m = 1'b1; vco_m = vc; end
    if (acc && dt == 6'h01) fvo_m = 1'b0;
    if (acc && raw) begin
      dt_m = dt;
      case (dt)
        6'h2B:   begin gsize = 5; npix = 4; end
        6'h2C:   begin gsize = 3; npix = 2; end
        default: begin gsize = 1; npix = 1; end
      endcase
      groups = n_send / gsize;
      for (int g = 0; g < groups; g++) begin
        base = g * gsize;
        if (dt == 6'h2A) exp_q.push_back(int'(pay_q[base]));
        else if (dt == 6'h2B)
          for (int k = 0; k < 4; k++)
            exp_q.push_back((int'(pay_q[base+k]) << 2) | ((int'(pay_q[base+4]) >> (2*k)) & 3));
        else begin
          exp_q.push_back((int'(pay_q[base]) << 4) | (int'(pay_q[base+2]) & 15));
          exp_q.push_back((int'(pay_q[base+1]) << 4) | (int'(pay_q[base+2]) >> 4));
        end
      end
    end
    span   = (groups == 0) ? 0 : (groups - 1) * gsize + npix;
    exp_pe = (acc && ((dt >= 6'h20 && !raw) || (raw && n_send < int'(wc)))) ? 1 : 0;
    exp_ce = (CRC_ON && acc && raw && n_send == int'(wc) && corrupt) ? 1 : 0;

    got = mon_n - p0;
    chk({tag, " pixel count"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < got && i < exp_q.size(); i++)
      chk({tag, " pixel"}, 32'(mon_pix[p0+i]), 32'(exp_q[i]));
    chk({tag, " lvo cycles"}, 32'(mon_lvo - l0), 32'(span));
    chk({tag, " dvo outside lvo"}, 32'(mon_bad - b0), 32'd0);
    chk({tag, " pkt_err pulses"}, 32'(mon_pe - e0), 32'(exp_pe));
    chk({tag, " crc_err pulses"}, 32'(mon_ce - c0), 32'(exp_ce));
    chk({tag, " fvo after last byte"}, 32'(fvo_at_end), 32'(fvo_m));
    chk({tag, " vco"}, 32'(vco), 32'(vco_m));
    chk({tag, " dt_o"}, 32'(dt_o), 32'(dt_m));
  endtask

  initial begin
    int r, n, wc;
    logic [5:0] dt;
    resetb = 1'b0; enable = 1'b1; phy_we = 1'b0; phy_data = 8'd0;
    vc_sel = 2'd0; vc_any = 1'b1; fvo_at_end = 1'b0;
    #12;
    chk("reset dato", 32'(dato), 32'd0);
    chk("reset dvo", 32'(dvo), 32'd0);
    chk("reset lvo", 32'(lvo), 32'd0);
    chk("reset fvo", 32'(fvo), 32'd0);
    chk("reset vco", 32'(vco), 32'd0);
    chk("reset dt_o", 32'(dt_o), 32'd0);
    chk("reset errs", 32'({pkt_err, crc_err}), 32'd0);
    @(posedge clk); #1 resetb = 1'b1;
    repeat (3) @(posedge clk);

    run_pkt("fs", 2'd1, 6'h00, 16'h1234, 0, 1'b0);
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt("raw8", 2'd0, 6'h2A, 16'd4, 4, 1'b0);
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE4};
    run_pkt("raw10", 2'd0, 6'h2B, 16'd5, 5, 1'b0);
    pay_q = '{8'h12, 8'h34, 8'hA5};
    run_pkt("raw12 good crc", 2'd0, 6'h2C, 16'd3, 3, 1'b0);
    run_pkt("raw12 bad crc", 2'd0, 6'h2C, 16'd3, 3, 1'b1);
    run_pkt("fe", 2'd1, 6'h01, 16'h0000, 0, 1'b0);

    vc_any = 1'b0; vc_sel = 2'd2;
    fill_pay(4);
    run_pkt("vc0 filtered", 2'd0, 6'h2A, 16'd4, 4, 1'b0);
    run_pkt("vc2 accepted", 2'd2, 6'h2A, 16'd4, 4, 1'b0);
    vc_any = 1'b1;

    fill_pay(10);
    run_pkt("raw10 truncated", 2'd0, 6'h2B, 16'd10, 7, 1'b0);
    fill_pay(6);
    run_pkt("after truncation", 2'd3, 6'h2C, 16'd6, 6, 1'b0);

    // Reset in the middle of a RAW8 line
    drive_byte(8'h2A); drive_byte(8'd8); drive_byte(8'd0); drive_byte(8'h00);
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    @(posedge clk); #2;
    chk("pre-reset lvo", 32'(lvo), 32'd1);
    resetb = 1'b0;
    #1;
    chk("async reset lvo", 32'(lvo), 32'd0);
    chk("async reset dvo", 32'(dvo), 32'd0);
    chk("async reset fvo", 32'(fvo), 32'd0);
    chk("async reset dt_o", 32'(dt_o), 32'd0);
    fvo_m = 1'b0; vco_m = 2'd0; dt_m = 6'd0;
    phy_we = 1'b0;
    @(posedge clk); #1 resetb = 1'b1;
    repeat (3) @(posedge clk);
    fill_pay(8);
    run_pkt("after reset", 2'd0, 6'h2A, 16'd8, 8, 1'b0);

    // Enable dropped mid-line
    run_pkt("fs before enable", 2'd3, 6'h00, 16'h0007, 0, 1'b0);
    drive_byte(8'h2A); drive_byte(8'd20); drive_byte(8'd0); drive_byte(8'h00);
    for (int i = 0; i < 6; i++) drive_byte(8'($urandom));
    @(posedge clk); #1;
    chk("pre-disable lvo", 32'(lvo), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable lvo", 32'(lvo), 32'd0);
    chk("disable dvo", 32'(dvo), 32'd0);
    chk("disable fvo", 32'(fvo), 32'd0);
    fvo_m = 1'b0; dt_m = 6'h2A;
    phy_we = 1'b0; enable = 1'b1;
    idle(6);
    fill_pay(9);
    run_pkt("after enable", 2'd1, 6'h2C, 16'd9, 9, 1'b0);

    // Random packets against the model
    for (int t = 0; t < 30; t++) begin
      vc_any = 1'($urandom_range(0, 1));
      vc_sel = 2'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        3:       dt = 6'h00;
        4:       dt = 6'h01;
        5:       dt = 6'h08;
        6:       dt = 6'h30;
        0, 7:    dt = 6'h2A;
        1, 8:    dt = 6'h2B;
        default: dt = 6'h2C;
      endcase
      if (dt >= 6'h10) begin
        wc = (dt == 6'h30) ? $urandom_range(0, 8) : $urandom_range(0, 30);
        n  = wc;
        if (dt != 6'h30 && wc > 2 && $urandom_range(0, 5) == 0) n = $urandom_range(1, wc - 1);
        fill_pay(wc);
        run_pkt("random long", 2'($urandom), dt, 16'(wc), n, ($urandom_range(0, 3) == 0));
      end
      else run_pkt("random short", 2'($urandom), dt, 16'($urandom), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
